// File: rtl/cpu_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_step_pkg
//   Shared definitions for the CPU step/run controller:
//     step_state_t            - controller FSM state encoding
//     SYNC_STAGES             - depth of every input synchronizer
//     DEBOUNCE_CYCLES_DEFAULT - 20 ms of stable level at 50 MHz
// -----------------------------------------------------------------------------
package cpu_step_pkg;

    typedef enum logic [1:0] {
        STEP_IDLE = 2'd0,
        STEP_HELD = 2'd1,
        RUN       = 2'd2
    } step_state_t;

    localparam int unsigned SYNC_STAGES             = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Level debouncer for an already-synchronized button input.
//   A new level is accepted only after it has differed from the accepted
//   level for DEBOUNCE_CYCLES consecutive cycles (minimum 2).
//
// Ports:
//   CLOCK_50MHz  in   system clock
//   Reset        in   synchronous, active-high reset
//   in_s         in   synchronized raw button level (active-low button)
//   out_db       out  debounced level, resets to 1 (released)
//   fall_pulse   out  one-cycle pulse in the cycle after out_db falls 1->0
// -----------------------------------------------------------------------------
module btn_debounce
    import cpu_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLOCK_50MHz,
    input  logic Reset,
    input  logic in_s,
    output logic out_db,
    output logic fall_pulse
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50MHz) begin
        if (Reset) begin
            out_db     <= 1'b1;
            cnt        <= '0;
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= 1'b0;
            if (in_s == out_db) begin
                // Any bounce back to the accepted level restarts the count.
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                out_db     <= in_s;
                cnt        <= '0;
                // Registered together with out_db, so it marks the first
                // cycle of the new low level.
                fall_pulse <= ~in_s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//   Turns the divided slow clock (run mode) or a debounced push-button
//   (step mode) into single-cycle clock-enable pulses for the CPU core,
//   all in the CLOCK_50MHz domain.
//
// Ports:
//   CLOCK_50MHz  in   system clock, all registers on its rising edge
//   Reset        in   synchronous, active-high reset
//   Clk_Slow     in   divider output, treated as an asynchronous level
//   Btn_Step_n   in   raw push-button, active-low
//   Sw_Mode      in   raw slide switch, 1 = run, 0 = step
//   Cpu_En       out  one-cycle enable pulse to the core
//   Step_Count   out  Cpu_En pulses issued, modulo 2^CNT_W
//   Led_Run      out  high while the controller is in RUN
// -----------------------------------------------------------------------------
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             CLOCK_50MHz,
    input  logic             Reset,
    input  logic             Clk_Slow,
    input  logic             Btn_Step_n,
    input  logic             Sw_Mode,
    output logic             Cpu_En,
    output logic [CNT_W-1:0] Step_Count,
    output logic             Led_Run
);

    // -------------------------------------------------------------------------
    // Input synchronizers; only the last stage is used downstream.
    // The button chain resets to 1 so reset never looks like a press.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] slow_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] mode_sync;

    always_ff @(posedge CLOCK_50MHz) begin
        if (Reset) begin
            slow_sync <= '0;
            btn_sync  <= '1;
            mode_sync <= '0;
        end else begin
            slow_sync <= {slow_sync[SYNC_STAGES-2:0], Clk_Slow};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0],  Btn_Step_n};
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], Sw_Mode};
        end
    end

    logic slow_s;
    logic btn_s;
    logic mode_s;

    assign slow_s = slow_sync[SYNC_STAGES-1];
    assign btn_s  = btn_sync[SYNC_STAGES-1];
    assign mode_s = mode_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Slow-clock rising-edge detect
    // -------------------------------------------------------------------------
    logic slow_prev;
    logic slow_rise;

    always_ff @(posedge CLOCK_50MHz) begin
        if (Reset) begin
            slow_prev <= 1'b0;
        end else begin
            slow_prev <= slow_s;
        end
    end

    assign slow_rise = slow_s & ~slow_prev;

    // -------------------------------------------------------------------------
    // Button debounce; keeps tracking in every state.
    // -------------------------------------------------------------------------
    logic btn_db;
    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLOCK_50MHz (CLOCK_50MHz),
        .Reset       (Reset),
        .in_s        (btn_s),
        .out_db      (btn_db),
        .fall_pulse  (press)
    );

    // -------------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // Mode changes take priority over press / slow_rise in the same cycle.
    // Led_Run is loaded alongside the state so it tracks the state register
    // without an extra cycle of lag.
    // -------------------------------------------------------------------------
    step_state_t state;

    always_ff @(posedge CLOCK_50MHz) begin
        if (Reset) begin
            state      <= STEP_IDLE;
            Cpu_En     <= 1'b0;
            Step_Count <= '0;
            Led_Run    <= 1'b0;
        end else begin
            Cpu_En <= 1'b0;
            case (state)
                STEP_IDLE: begin
                    if (mode_s) begin
                        state   <= RUN;
                        Led_Run <= 1'b1;
                    end else if (press) begin
                        state      <= STEP_HELD;
                        Cpu_En     <= 1'b1;
                        Step_Count <= Step_Count + CNT_W'(1);
                    end
                end
                STEP_HELD: begin
                    if (mode_s) begin
                        state   <= RUN;
                        Led_Run <= 1'b1;
                    end else if (btn_db) begin
                        state <= STEP_IDLE;
                    end
                end
                RUN: begin
                    if (!mode_s) begin
                        // Returning to step mode only re-arms on a fresh
                        // press edge, so a held button stays inert.
                        state   <= STEP_IDLE;
                        Led_Run <= 1'b0;
                    end else if (slow_rise) begin
                        Cpu_En     <= 1'b1;
                        Step_Count <= Step_Count + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= STEP_IDLE;
                    Led_Run <= 1'b0;
                end
            endcase
        end
    end

endmodule
